seg7_scan_decoder: RTL
======================

// Module: seg7_scan_decoder
// PURPOSE
//  Inverse of the team's hex-to-7-segment decoder. Samples a scanned, multiplexed
//  7-segment display bus (segments + one-hot digit select) and recovers the hex
//  nibble and digit index. Captures on stability, not on a strobe, so it can sit
//  on display pins in loopback self-test. Words are queued in a small FIFO and
//  drained over a valid/ready port.
// PARAMETERS
//  NDIG          4   number of scanned digits (>=2); DW = $clog2(NDIG)
//  STABLE_CYCLES 3   consecutive identical samples required before capture (1..255)
//  DEPTH         4   output FIFO depth, power of two (2..16)
// PORTS
//  clk        in   1        clock, all flops rising-edge
//  rst        in   1        asynchronous, active-high reset
//  seg_in     in   7        segments {g,f,e,d,c,b,a}, bit0 = a
//  dig_in     in   NDIG     digit select, one-hot, bit i = digit i
//  out_valid  out  1        FIFO head valid
//  out_ready  in   1        consumer accepts head when out_valid & out_ready
//  out_hex    out  4        decoded nibble (0 when out_err)
//  out_digit  out  DW       index of the set dig_in bit
//  out_err    out  1        captured pattern is not a legal hex glyph
//  ovf        out  1        sticky: capture dropped because FIFO full
//  ovf_clr    in   1        synchronous clear of ovf (wins over same-cycle set? no: set wins)
// BEHAVIOUR
//  - Reset: out_valid=0, out_hex=0, out_digit=0, out_err=0, ovf=0, FIFO empty,
//    sample reg=0, cnt=0, FSM=IDLE. Reset mid-episode discards the count and all queued words.
//  - Sample reg S <= {dig_in,seg_in} every edge. Change = new sample != S.
//  - FSM: IDLE --change & capturable--> COUNT (cnt=1); COUNT: change -> cnt=1 (stay),
//    else cnt++; cnt==STABLE_CYCLES -> push word, go HELD; HELD: change -> COUNT(cnt=1)
//    if capturable else IDLE. One push per stable episode; no re-push while held.
//  - Capturable: dig_in exactly one-hot AND seg_in != 7'h00. Otherwise (blank/
//    non-one-hot) any state -> IDLE, no push.
//  - Glyph table (seg hex -> nibble): 3F:0 06:1 5B:2 4F:3 66:4 6D:5 7D:6 07:7
//    7F:8 6F:9 77:A 7C:b 39:C 5E:d 79:E 71:F. Other non-zero -> out_err=1, out_hex=0.
//  - Latency: input held from edge k (first edge sampling it) -> push at edge
//    k+STABLE_CYCLES; out_valid=1 after edge k+STABLE_CYCLES+1 if FIFO was empty.
//  - FIFO: first-word registered outputs; pop on out_valid&out_ready. Push when
//    full and no pop: word dropped, ovf set. Push+pop same cycle when full: both
//    succeed, no ovf. Push+pop when empty: word appears next cycle (no bypass).
//  - ovf: set and ovf_clr same cycle -> ovf stays 1.
//  - Outputs stable while out_valid & !out_ready.
// CONFIGURATION
//  SEG7_SCAN_ACTIVE_LOW_EN: defined -> seg_in and dig_in are inverted at the input
//    before S (common-anode boards); blank = seg_in 7'h7F, all logic else identical.
//    Undefined -> active-high as above.
// TESTING
//  1 Reset: rst high mid-COUNT with 2 words queued -> all outputs 0, out_valid low
//    on the first edge after release.
//  2 seg_in=7'h5B, dig_in=4'b0100 held, STABLE_CYCLES=3, ready=1 -> one word
//    {hex=2,digit=2,err=0}, out_valid rises at edge k+4, single pulse only.
//  3 Glitch: 7'h06 for 2 cycles then 7'h07 held -> only {hex=7} emitted, no 1.
//  4 seg_in=7'h49 held, dig one-hot -> word with out_err=1, out_hex=0.
//  5 ready=0, 5 distinct stable glyphs (DEPTH=4) -> first 4 queued, 5th dropped,
//    ovf=1; ovf_clr pulse -> ovf=0; drain yields words in order.
//  6 dig_in=4'b0110 or seg_in=0 held 10 cycles -> no push; all 16 glyphs
//    sweep -> nibbles 0..F in order; rerun with SEG7_SCAN_ACTIVE_LOW_EN.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// Recovers hex nibble and digit index from a scanned 7-segment bus, capturing on input stability.
// Define SEG7_SCAN_ACTIVE_LOW_EN for common-anode boards (segments and digit selects inverted).
module seg7_scan_decoder #(
   parameter  int NDIG          = 4,
   parameter  int STABLE_CYCLES = 3,
   parameter  int DEPTH         = 4,
   localparam int DW            = (NDIG > 1) ? $clog2(NDIG) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [6:0]      seg_in,
   input  logic [NDIG-1:0] dig_in,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [3:0]      out_hex,
   output logic [DW-1:0]   out_digit,
   output logic            out_err,
   output logic            ovf,
   input  logic            ovf_clr
);

   localparam int SW = NDIG + 7;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_COUNT = 2'd1;
   localparam logic [1:0] ST_HELD  = 2'd2;

   typedef struct packed {
      logic          err;
      logic [DW-1:0] digit;
      logic [3:0]    hex;
   } word_t;

   logic [SW-1:0]   smp;
   logic [6:0]      smp_seg;
   logic [NDIG-1:0] smp_dig;
   logic            capturable;
   logic            change;

   logic [SW-1:0]   s_q;
   logic [1:0]      state_q, state_d;
   logic [7:0]      cnt_q, cnt_d;
   logic            push_q, push_d;
   word_t           word_q, word_d;

   word_t           mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q, count_d;
   logic            ovf_q, ovf_d;
   logic            full, pop, wr_en, ovf_set;
   word_t           head;

`ifdef SEG7_SCAN_ACTIVE_LOW_EN
   assign smp = ~{dig_in, seg_in};
`else
   assign smp = {dig_in, seg_in};
`endif

   assign smp_seg    = smp[6:0];
   assign smp_dig    = smp[SW-1:7];
   assign capturable = (smp_dig != '0) && ((smp_dig & (smp_dig - 1'b1)) == '0)
                       && (smp_seg != 7'h00);
   assign change     = (smp != s_q);

   function automatic word_t decode(input logic [SW-1:0] s);
      word_t w;
      w.err   = 1'b0;
      w.hex   = 4'h0;
      w.digit = '0;
      case (s[6:0])
         7'h3F: w.hex = 4'h0;
         7'h06: w.hex = 4'h1;
         7'h5B: w.hex = 4'h2;
         7'h4F: w.hex = 4'h3;
         7'h66: w.hex = 4'h4;
         7'h6D: w.hex = 4'h5;
         7'h7D: w.hex = 4'h6;
         7'h07: w.hex = 4'h7;
         7'h7F: w.hex = 4'h8;
         7'h6F: w.hex = 4'h9;
         7'h77: w.hex = 4'hA;
         7'h7C: w.hex = 4'hB;
         7'h39: w.hex = 4'hC;
         7'h5E: w.hex = 4'hD;
         7'h79: w.hex = 4'hE;
         7'h71: w.hex = 4'hF;
         default: w.err = 1'b1;
      endcase
      for (int i = 0; i < NDIG; i++) begin
         if (s[7+i]) w.digit = DW'(i);
      end
      return w;
   endfunction

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      state_d = state_q;
      cnt_d   = cnt_q;
      push_d  = 1'b0;
      if (!capturable) begin
         state_d = ST_IDLE;
         cnt_d   = 8'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (change) begin
                  state_d = ST_COUNT;
                  cnt_d   = 8'd1;
               end
            end
            ST_COUNT: begin
               if (change) begin
                  cnt_d = 8'd1;
               end else if (cnt_q == 8'(STABLE_CYCLES)) begin
                  push_d  = 1'b1;
                  state_d = ST_HELD;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            ST_HELD: begin
               if (change) begin
                  state_d = ST_COUNT;
                  cnt_d   = 8'd1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = 8'd0;
            end
         endcase
      end
   end

   // Word is taken from the stable sample register, so it is registered with the push pulse.
   assign word_d = decode(s_q);

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst) begin
         s_q     <= '0;
         state_q <= ST_IDLE;
         cnt_q   <= 8'd0;
         push_q  <= 1'b0;
         word_q  <= '0;
      end else begin
         s_q     <= smp;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         push_q  <= push_d;
         word_q  <= word_d;
      end
   end

   assign full    = (count_q == CW'(DEPTH));
   assign out_valid = (count_q != '0);
   assign pop     = out_valid & out_ready;
   assign wr_en   = push_q & (~full | pop);
   assign ovf_set = push_q & full & ~pop;
   assign ovf_d   = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

   always_comb begin
      count_d = count_q;
      case ({wr_en, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   // NOTE: storage needs no reset; stale entries are never visible because outputs are gated by out_valid.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= word_q;
   end

   assign head      = mem_q[rd_ptr_q];
   assign out_hex   = out_valid ? head.hex   : 4'h0;
   assign out_digit = out_valid ? head.digit : '0;
   assign out_err   = out_valid ? head.err   : 1'b0;
   assign ovf       = ovf_q;

endmodule
